seg7_frame_decoder: RTL and testbench

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

---
 rtl/seg7_frame_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
// Assembles eight active-low 7-segment digits into a 32-bit word, one frame at a time.
// Optional partial-frame idle timeout is compiled in with macro SEG7_DECODER_TIMEOUT_EN.
module seg7_frame_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        segValid,
  input  logic [2:0]  segIndex,
  input  logic [6:0]  segPattern,
  output logic        segReady,
  output logic [31:0] dataOut,
  output logic        dataValid,
  output logic        frameError,
  output logic [7:0]  digitMask,
  output logic        timeoutPulse
);

  localparam int unsigned DIGITS = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = DIGITS * NIB_W;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                tpulse_q, tpulse_d;
  logic                ready_q, ready_d;

  logic                transfer;
  logic                timeout_hit;
  logic [NIB_W:0]      dec;
  logic [NIB_W-1:0]    nib;
  logic                pat_ok;
  logic [WORD_W-1:0]   asm_wr;
  logic [DIGITS-1:0]   mask_wr;
  logic                err_wr;

  // Returns {valid, nibble}; unknown patterns decode to nibble 0 with valid cleared.
  function automatic logic [NIB_W:0] seg_decode(input logic [SEG_W-1:0] pat);
    case (pat)
      7'h40:   seg_decode = 5'h10;
      7'h79:   seg_decode = 5'h11;
      7'h24:   seg_decode = 5'h12;
      7'h30:   seg_decode = 5'h13;
      7'h19:   seg_decode = 5'h14;
      7'h12:   seg_decode = 5'h15;
      7'h02:   seg_decode = 5'h16;
      7'h78:   seg_decode = 5'h17;
      7'h00:   seg_decode = 5'h18;
      7'h10:   seg_decode = 5'h19;
      7'h08:   seg_decode = 5'h1A;
      7'h03:   seg_decode = 5'h1B;
      7'h46:   seg_decode = 5'h1C;
      7'h21:   seg_decode = 5'h1D;
      7'h06:   seg_decode = 5'h1E;
      7'h0E:   seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  assign transfer = segValid & ready_q;
  assign dec      = seg_decode(segPattern);
  assign nib      = dec[NIB_W-1:0];
  assign pat_ok   = dec[NIB_W];
  assign mask_wr  = mask_q | (DIGITS'(1) << segIndex);
  assign err_wr   = err_q | ~pat_ok;

  // Frame contents as they would look after accepting the presented digit.
  always_comb begin : asm_write
    asm_wr = asm_q;
    asm_wr[{segIndex, 2'b00} +: NIB_W] = nib;
  end

`ifdef SEG7_DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == S_COLLECT) && !transfer &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle-gap counter: only runs inside a partial frame, restarts on every accepted digit.
  always_comb begin : cnt_next
    cnt_d = '0;
    if ((state_q == S_COLLECT) && !transfer && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : cnt_reg
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Frame FSM: next state, frame storage and result strobes.
  always_comb begin : fsm_next
    state_d  = state_q;
    mask_d   = mask_q;
    asm_d    = asm_q;
    err_d    = err_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tpulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          asm_d   = asm_wr;
          mask_d  = mask_wr;
          err_d   = err_wr;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (transfer) begin
          asm_d  = asm_wr;
          mask_d = mask_wr;
          err_d  = err_wr;
          if (mask_wr == {DIGITS{1'b1}}) begin
            state_d = S_DONE;
            data_d  = asm_wr;
            valid_d = 1'b1;
            ferr_d  = err_wr;
          end
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          mask_d   = '0;
          asm_d    = '0;
          err_d    = 1'b0;
          tpulse_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = '0;
        asm_d   = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
        asm_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Ready is registered alongside the state so it is low for exactly the DONE cycle.
  assign ready_d = (state_d != S_DONE);

  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    if (reset) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      tpulse_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      asm_q    <= asm_d;
      err_q    <= err_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      tpulse_q <= tpulse_d;
      ready_q  <= ready_d;
    end
  end

  assign segReady     = ready_q;
  assign dataOut      = data_q;
  assign dataValid    = valid_q;
  assign frameError   = ferr_q;
  assign digitMask    = mask_q;
  assign timeoutPulse = tpulse_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder: directed frame table, corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_seg7_frame_decoder;

  localparam int unsigned TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        segValid;
  logic [2:0]  segIndex;
  logic [6:0]  segPattern;
  logic        segReady;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        frameError;
  logic [7:0]  digitMask;
  logic        timeoutPulse;

  always #5 clk = ~clk;

  seg7_frame_decoder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .segValid     (segValid),
    .segIndex     (segIndex),
    .segPattern   (segPattern),
    .segReady     (segReady),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .frameError   (frameError),
    .digitMask    (digitMask),
    .timeoutPulse (timeoutPulse)
  );

  // Glyph for hex value k is SEG_TBL[k].
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks   = 0;
  int failures = 0;

  // Reference model: which digits have arrived, their values, and the last result.
  int          m_nib [8];
  bit          m_got [8];
  bit          m_err;
  bit          m_done;
  bit          m_valid;
  bit          m_ferr;
  bit          m_tp;
  int          m_gap;
  logic [31:0] m_out;

  typedef struct {
    int               n;
    logic [8:0][2:0]  idx;
    logic [8:0][6:0]  pat;
    logic [31:0]      exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [6:0] pat, output int nib, output bit ok);
    nib = 0;
    ok  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (SEG_TBL[k] == pat) begin
        nib = k;
        ok  = 1'b1;
      end
    end
  endtask

  task automatic model_clear_frame();
    for (int i = 0; i < 8; i++) begin
      m_got[i] = 1'b0;
      m_nib[i] = 0;
    end
    m_err = 1'b0;
    m_gap = 0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    m_done  = 1'b0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_tp    = 1'b0;
    m_out   = 32'h0;
  endtask

  function automatic int got_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_got[i]);
    return c;
  endfunction

  function automatic logic [7:0] exp_mask();
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++) if (m_got[i]) m[i] = 1'b1;
    return m;
  endfunction

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic model_step(input bit v, input int idx, input logic [6:0] pat);
    int nib;
    bit ok;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_tp    = 1'b0;
    if (m_done) begin
      model_clear_frame();
      m_done = 1'b0;
    end else if (v) begin
      ref_decode(pat, nib, ok);
      m_nib[idx] = nib;
      m_got[idx] = 1'b1;
      if (!ok) m_err = 1'b1;
      m_gap = 0;
      if (got_count() == 8) begin
        m_out = 32'h0;
        for (int i = 0; i < 8; i++) m_out += 32'(m_nib[i]) * (32'd1 << (4 * i));
        m_valid = 1'b1;
        m_ferr  = m_err;
        m_done  = 1'b1;
      end
    end else if (got_count() != 0) begin
      m_gap++;
`ifdef SEG7_DECODER_TIMEOUT_EN
      if (m_gap == int'(TO_CYC)) begin
        model_clear_frame();
        m_tp = 1'b1;
      end
`endif
    end
  endtask

  task automatic compare_all();
    check("ready", 32'(segReady), 32'(!m_done));
    check("valid", 32'(dataValid), 32'(m_valid));
    check("data", dataOut, m_out);
    check("ferr", 32'(frameError), 32'(m_ferr));
    check("mask", 32'(digitMask), 32'(exp_mask()));
    check("tpulse", 32'(timeoutPulse), 32'(m_tp));
  endtask

  task automatic cycle(input bit v, input int idx, input logic [6:0] pat);
    segValid   = v;
    segIndex   = 3'(idx);
    segPattern = pat;
    model_step(v, idx, pat);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, 32'(segReady), 32'd1);
    check({tag, ".data"}, dataOut, 32'h0);
    check({tag, ".valid"}, 32'(dataValid), 32'd0);
    check({tag, ".ferr"}, 32'(frameError), 32'd0);
    check({tag, ".mask"}, 32'(digitMask), 32'd0);
    check({tag, ".tpulse"}, 32'(timeoutPulse), 32'd0);
  endtask

  initial begin
    logic [6:0] p0 [8];
    bit         v;

    p0 = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    for (int i = 0; i < 8; i++) begin
      vecs[0].idx[i] = 3'(i);
      vecs[0].pat[i] = p0[i];
      vecs[1].idx[i] = 3'(7 - i);
      vecs[1].pat[i] = 7'h0E;
      vecs[2].idx[i] = 3'(i);
      vecs[2].pat[i] = (i == 3) ? 7'h7F : 7'h40;
    end
    vecs[0].n = 8; vecs[0].exp_data = 32'h12345678; vecs[0].exp_err = 1'b0;
    vecs[1].n = 8; vecs[1].exp_data = 32'hFFFFFFFF; vecs[1].exp_err = 1'b0;
    vecs[2].n = 8; vecs[2].exp_data = 32'h00000000; vecs[2].exp_err = 1'b1;
    vecs[3].n = 9; vecs[3].exp_data = 32'h00000002; vecs[3].exp_err = 1'b0;
    vecs[3].idx[0] = 3'd0; vecs[3].pat[0] = 7'h79;
    vecs[3].idx[1] = 3'd0; vecs[3].pat[1] = 7'h24;
    for (int i = 2; i < 9; i++) begin
      vecs[3].idx[i] = 3'(i - 1);
      vecs[3].pat[i] = 7'h40;
    end

    reset      = 1'b1;
    segValid   = 1'b0;
    segIndex   = 3'd0;
    segPattern = 7'h00;
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    // Directed frames.
    for (int t = 0; t < 4; t++) begin
      for (int d = 0; d < vecs[t].n; d++) begin
        cycle(1'b1, int'(vecs[t].idx[d]), vecs[t].pat[d]);
      end
      check("tbl.valid", 32'(dataValid), 32'd1);
      check("tbl.data", dataOut, vecs[t].exp_data);
      check("tbl.ferr", 32'(frameError), 32'(vecs[t].exp_err));
      check("tbl.ready", 32'(segReady), 32'd0);
      cycle(1'b0, 0, 7'h00);
      check("tbl.valid_one_cycle", 32'(dataValid), 32'd0);
      check("tbl.mask_clear", 32'(digitMask), 32'd0);
      check("tbl.data_hold", dataOut, vecs[t].exp_data);
    end

    // segValid held high through the DONE cycle.
    for (int i = 0; i < 7; i++) cycle(1'b1, i, 7'h40);
    cycle(1'b1, 7, 7'h79);
    check("hold.data", dataOut, 32'h10000000);
    cycle(1'b1, 0, 7'h79);
    check("hold.no_xfer_mask", 32'(digitMask), 32'd0);
    check("hold.ready_back", 32'(segReady), 32'd1);
    cycle(1'b1, 0, 7'h79);
    check("hold.next_frame", 32'(digitMask), 32'd1);

    // Reset in the middle of a frame.
    cycle(1'b1, 1, 7'h24);
    cycle(1'b1, 2, 7'h30);
    check("mid.mask", 32'(digitMask), 32'h07);
    segValid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    check_reset_values("midrst_hold");
    reset = 1'b0;
    for (int i = 3; i < 8; i++) cycle(1'b1, i, 7'h40);
    check("midrst.no_valid", 32'(dataValid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 7'h79);
    check("midrst.fresh_frame", dataOut, 32'h00000111);

`ifdef SEG7_DECODER_TIMEOUT_EN
    // Partial frame aborted after TO_CYC idle cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 7'h40);
    for (int i = 0; i < int'(TO_CYC) - 1; i++) cycle(1'b0, 0, 7'h00);
    check("to.not_yet", 32'(timeoutPulse), 32'd0);
    cycle(1'b0, 0, 7'h00);
    check("to.pulse", 32'(timeoutPulse), 32'd1);
    check("to.mask", 32'(digitMask), 32'd0);
    check("to.valid", 32'(dataValid), 32'd0);
    cycle(1'b0, 0, 7'h00);
    check("to.pulse_one_cycle", 32'(timeoutPulse), 32'd0);
    // A transfer on the would-be timeout cycle wins.
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 7'h40);
    for (int i = 0; i < int'(TO_CYC) - 1; i++) cycle(1'b0, 0, 7'h00);
    cycle(1'b1, 5, 7'h40);
    check("to.prio_pulse", 32'(timeoutPulse), 32'd0);
    check("to.prio_mask", 32'(digitMask), 32'h27);
`endif

    // Randomized traffic, with occasional long idle gaps.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int g = 0; g < 20; g++) cycle(1'b0, 0, 7'h00);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          cycle(v, int'($urandom_range(0, 7)), 7'($urandom));
        end else begin
          cycle(v, int'($urandom_range(0, 7)), SEG_TBL[$urandom_range(0, 15)]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
